// File: rtl/ps2_init_pkg.sv
// Shared constants for the PS/2 mouse bring-up sequencer: state encoding,
// protocol bytes, the command list and the error codes reported to the host.
package ps2_init_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD     = 4'd1,
    ST_SEND     = 4'd2,
    ST_WAIT_ACK = 4'd3,
    ST_WAIT_BAT = 4'd4,
    ST_WAIT_ID  = 4'd5,
    ST_NEXT     = 4'd6,
    ST_RETRY    = 4'd7,
    ST_DONE     = 4'd8,
    ST_FAIL     = 4'd9
  } state_e;

  localparam logic [7:0] PS2_CMD_RESET     = 8'hFF;
  localparam logic [7:0] PS2_CMD_DEFAULTS  = 8'hF6;
  localparam logic [7:0] PS2_CMD_ENABLE    = 8'hF4;
  localparam logic [7:0] PS2_RSP_ACK       = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND    = 8'hFE;
  localparam logic [7:0] PS2_RSP_BAT_OK    = 8'hAA;
  localparam logic [7:0] PS2_RSP_BAT_FAIL  = 8'hFC;
  localparam logic [7:0] PS2_RSP_MOUSE_ID  = 8'h00;

  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_TX_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_RSP_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_BAD_RSP     = 2'd3;

  localparam logic [1:0] LAST_STEP = 2'd2;

  function automatic logic [7:0] cmd_for_step(input logic [1:0] step);
    case (step)
      2'd0:    cmd_for_step = PS2_CMD_RESET;
      2'd1:    cmd_for_step = PS2_CMD_DEFAULTS;
      2'd2:    cmd_for_step = PS2_CMD_ENABLE;
      default: cmd_for_step = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ps2_mouse_init_sequencer.sv
// Walks the PS/2 mouse through reset / set-defaults / enable-stream, checking each
// response byte, retrying a command on any failure and reporting done or error.
//
// Transmitter handshake: send_command is held high for the whole SEND state; the
// transmitter answers with a level on command_was_sent or error_communication_timed_out,
// and clears that level once send_command falls. Received bytes are single-cycle
// strobes on received_data_en with received_data valid in that same cycle.
module ps2_mouse_init_sequencer
  import ps2_init_pkg::*;
#(
  parameter int unsigned CLOCK_CYCLES_FOR_25MS    = 1000000,
  parameter int unsigned CLOCK_CYCLES_FOR_750MS   = 30000000,
  parameter int unsigned NUMBER_OF_BITS_FOR_TIMER = 25,
  parameter int unsigned MAX_RETRIES              = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  output logic [7:0] the_command,
  output logic       send_command,
  output logic       busy,
  output logic       init_done,
  output logic       init_error,
  output logic [1:0] error_code,
  output logic [3:0] debug_state
);

  localparam int unsigned TW      = NUMBER_OF_BITS_FOR_TIMER;
  localparam int unsigned RETRY_W = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0]      T_25MS    = TW'(CLOCK_CYCLES_FOR_25MS);
  localparam logic [TW-1:0]      T_750MS   = TW'(CLOCK_CYCLES_FOR_750MS);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  state_e             state_q, state_d;
  logic [1:0]         step_q, step_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [1:0]         cause_q, cause_d;
  logic [7:0]         the_command_q, the_command_d;
  logic               init_done_q, init_done_d;
  logic               init_error_q, init_error_d;
  logic [1:0]         error_code_q, error_code_d;

  logic [TW-1:0] timer_limit;
  logic          timer_term;
  logic          in_wait;

  // Only the BAT wait uses the long limit; everything else is a per-command response window.
  assign timer_limit = (state_q == ST_WAIT_BAT) ? T_750MS : T_25MS;
  assign timer_term  = (timer_q == timer_limit);
  assign in_wait     = (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_BAT) ||
                       (state_q == ST_WAIT_ID);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      step_q        <= '0;
      retry_q       <= '0;
      timer_q       <= '0;
      cause_q       <= ERR_NONE;
      the_command_q <= '0;
      init_done_q   <= 1'b0;
      init_error_q  <= 1'b0;
      error_code_q  <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      retry_q       <= retry_d;
      timer_q       <= timer_d;
      cause_q       <= cause_d;
      the_command_q <= the_command_d;
      init_done_q   <= init_done_d;
      init_error_q  <= init_error_d;
      error_code_q  <= error_code_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    retry_d       = retry_q;
    timer_d       = (in_wait && !timer_term) ? timer_q + 1'b1 : timer_q;
    cause_d       = cause_q;
    the_command_d = the_command_q;
    init_done_d   = init_done_q;
    init_error_d  = init_error_q;
    error_code_d  = error_code_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          state_d      = ST_LOAD;
          step_d       = '0;
          retry_d      = '0;
          init_done_d  = 1'b0;
          init_error_d = 1'b0;
          error_code_d = ERR_NONE;
        end
      end

      ST_LOAD: begin
        the_command_d = cmd_for_step(step_q);
        state_d       = ST_SEND;
      end

      ST_SEND: begin
        if (command_was_sent) begin
          state_d = ST_WAIT_ACK;
          timer_d = '0;
        end else if (error_communication_timed_out) begin
          state_d = ST_RETRY;
          cause_d = ERR_TX_TIMEOUT;
        end
      end

      // A byte arriving on the terminal-count cycle takes priority over the timeout.
      ST_WAIT_ACK: begin
        if (received_data_en) begin
          if (received_data == PS2_RSP_ACK) begin
            if (step_q == 2'd0) begin
              state_d = ST_WAIT_BAT;
              timer_d = '0;
            end else begin
              state_d = ST_NEXT;
            end
          end else begin
            state_d = ST_RETRY;
            cause_d = ERR_BAD_RSP;
          end
        end else if (timer_term) begin
          state_d = ST_RETRY;
          cause_d = ERR_RSP_TIMEOUT;
        end
      end

      ST_WAIT_BAT: begin
        if (received_data_en) begin
          if (received_data == PS2_RSP_BAT_OK) begin
            state_d = ST_WAIT_ID;
            timer_d = '0;
          end else begin
            state_d = ST_RETRY;
            cause_d = ERR_BAD_RSP;
          end
        end else if (timer_term) begin
          state_d = ST_RETRY;
          cause_d = ERR_RSP_TIMEOUT;
        end
      end

      ST_WAIT_ID: begin
        if (received_data_en) begin
          if (received_data == PS2_RSP_MOUSE_ID) begin
            state_d = ST_NEXT;
          end else begin
            state_d = ST_RETRY;
            cause_d = ERR_BAD_RSP;
          end
        end else if (timer_term) begin
          state_d = ST_RETRY;
          cause_d = ERR_RSP_TIMEOUT;
        end
      end

      ST_NEXT: begin
        if (step_q == LAST_STEP) begin
          state_d     = ST_DONE;
          init_done_d = 1'b1;
        end else begin
          step_d  = step_q + 2'd1;
          retry_d = '0;
          state_d = ST_LOAD;
        end
      end

      // Spending a cycle here lets the transmitter drop its status before the re-send.
      ST_RETRY: begin
        if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 1'b1;
          state_d = ST_LOAD;
        end else begin
          state_d      = ST_FAIL;
          init_error_d = 1'b1;
          error_code_d = cause_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign the_command  = the_command_q;
  assign send_command = (state_q == ST_SEND);
  assign busy         = !((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_FAIL));
  assign init_done    = init_done_q;
  assign init_error   = init_error_q;
  assign error_code   = error_code_q;
  assign debug_state  = state_q;

endmodule

// File: tb/tb_ps2_mouse_init_sequencer.sv
// Bench for the PS/2 mouse bring-up sequencer: a transmitter/mouse model answers each
// command according to a per-attempt outcome script; a list-level model predicts results.
module tb_ps2_mouse_init_sequencer;

  localparam int T25     = 200;
  localparam int T750    = 2000;
  localparam int MAX_RTY = 3;

  localparam int OC_OK      = 0;
  localparam int OC_TXTO    = 1;
  localparam int OC_BADACK  = 2;
  localparam int OC_NOREPLY = 3;
  localparam int OC_BATFAIL = 4;
  localparam int OC_IDBAD   = 5;
  localparam int OC_NOBAT   = 6;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       command_was_sent;
  logic       error_communication_timed_out;
  logic [7:0] the_command;
  logic       send_command;
  logic       busy;
  logic       init_done;
  logic       init_error;
  logic [1:0] error_code;
  logic [3:0] debug_state;

  int vectors;
  int miscompares;
  int send_count;
  logic send_prev;

  logic [7:0] cmd_tbl[3];
  int         script_q[$];
  logic [7:0] exp_q[$];
  int         exp_step_q[$];
  int         used;
  bit         exp_done;
  bit         exp_err;
  int         exp_code;

  ps2_mouse_init_sequencer #(
    .CLOCK_CYCLES_FOR_25MS    (T25),
    .CLOCK_CYCLES_FOR_750MS   (T750),
    .NUMBER_OF_BITS_FOR_TIMER (25),
    .MAX_RETRIES              (MAX_RTY)
  ) dut (
    .clk                           (clk),
    .reset                         (reset),
    .start                         (start),
    .received_data                 (received_data),
    .received_data_en              (received_data_en),
    .command_was_sent              (command_was_sent),
    .error_communication_timed_out (error_communication_timed_out),
    .the_command                   (the_command),
    .send_command                  (send_command),
    .busy                          (busy),
    .init_done                     (init_done),
    .init_error                    (init_error),
    .error_code                    (error_code),
    .debug_state                   (debug_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (send_command && !send_prev) send_count++;
    send_prev = send_command;
  end

  // ---------------- reference model ----------------
  // Works on whole attempts: each attempt either completes its command or costs one retry.
  task automatic model_run(output bit term);
    int step;
    int r;
    int cause;
    exp_q.delete();
    exp_step_q.delete();
    exp_done = 0;
    exp_err  = 0;
    exp_code = 0;
    term     = 0;
    used     = 0;
    step     = 0;
    r        = 0;
    for (int i = 0; i < script_q.size(); i++) begin
      exp_q.push_back(cmd_tbl[step]);
      exp_step_q.push_back(step);
      used++;
      if (script_q[i] == OC_OK) begin
        if (step == 2) begin
          exp_done = 1;
          term = 1;
          break;
        end
        step++;
        r = 0;
      end else begin
        if (script_q[i] == OC_TXTO) cause = 1;
        else if (script_q[i] == OC_NOREPLY || script_q[i] == OC_NOBAT) cause = 2;
        else cause = 3;
        if (r < MAX_RTY) r++;
        else begin
          exp_err  = 1;
          exp_code = cause;
          term     = 1;
          break;
        end
      end
    end
  endtask

  function automatic logic [7:0] pick_not(input logic [7:0] avoid, input logic [7:0] fav);
    logic [7:0] b;
    if ($urandom_range(0, 1) == 1) return fav;
    do b = 8'($urandom_range(0, 255)); while (b == avoid);
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    received_data    = b;
    received_data_en = 1'b1;
    @(negedge clk);
    received_data_en = 1'b0;
    received_data    = 8'h00;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_send(output bit ok);
    int n = 0;
    while (!send_command && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = send_command;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL send_wait: send_command=%0b after %0d cycles, required 1", send_command, n);
    end
  endtask

  task automatic do_attempt(input int step, input int oc, input logic [7:0] exp_cmd,
                            output bit ok);
    int n;
    wait_send(ok);
    if (!ok) return;
    vectors++;
    if (the_command !== exp_cmd) begin
      miscompares++;
      $display("FAIL the_command: got %02h required %02h", the_command, exp_cmd);
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    if (oc == OC_TXTO) error_communication_timed_out = 1'b1;
    else command_was_sent = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (send_command && n < 20);
    command_was_sent              = 1'b0;
    error_communication_timed_out = 1'b0;
    vectors++;
    if (send_command !== 1'b0) begin
      miscompares++;
      $display("FAIL send_release: send_command=%0b required 0", send_command);
      ok = 0;
      return;
    end
    if (oc == OC_TXTO || oc == OC_NOREPLY) return;
    if (step != 0 || oc == OC_BADACK) begin
      if (oc == OC_OK) send_byte(8'hFA);
      else send_byte(pick_not(8'hFA, 8'hFE));
      return;
    end
    send_byte(8'hFA);
    if (oc == OC_NOBAT) return;
    if (oc == OC_BATFAIL) begin
      send_byte(pick_not(8'hAA, 8'hFC));
      return;
    end
    send_byte(8'hAA);
    if (oc == OC_IDBAD) send_byte(pick_not(8'h00, 8'h03));
    else send_byte(8'h00);
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    ok = !busy;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL busy_timeout: busy=%0b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic check_end(input bit d, input bit e, input int code, input int sends);
    vectors++;
    if (init_done !== d) begin
      miscompares++;
      $display("FAIL init_done: got %0b required %0b", init_done, d);
    end
    vectors++;
    if (init_error !== e) begin
      miscompares++;
      $display("FAIL init_error: got %0b required %0b", init_error, e);
    end
    vectors++;
    if (error_code !== 2'(code)) begin
      miscompares++;
      $display("FAIL error_code: got %0d required %0d", error_code, code);
    end
    vectors++;
    if (send_count !== sends) begin
      miscompares++;
      $display("FAIL send_phases: got %0d required %0d", send_count, sends);
    end
  endtask

  task automatic run_script(input bit pulse_mid);
    bit term;
    bit ok;
    model_run(term);
    send_count = 0;
    pulse_start();
    vectors++;
    if (busy !== 1'b1 || init_done !== 1'b0 || init_error !== 1'b0 || error_code !== 2'd0) begin
      miscompares++;
      $display("FAIL start_clear: busy=%0b done=%0b err=%0b code=%0d required 1/0/0/0",
               busy, init_done, init_error, error_code);
    end
    for (int i = 0; i < used; i++) begin
      do_attempt(exp_step_q[i], script_q[i], exp_q[i], ok);
      if (!ok) return;
      if (pulse_mid && i == 0) pulse_start();
    end
    wait_idle(ok);
    if (!ok) return;
    check_end(exp_done, exp_err, exp_code, used);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({the_command, send_command, busy, init_done, init_error, error_code} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got cmd=%02h send=%0b busy=%0b done=%0b err=%0b code=%0d required all 0",
               the_command, send_command, busy, init_done, init_error, error_code);
    end
  endtask

  task automatic test_basic();
    script_q = '{OC_OK, OC_OK, OC_OK};
    run_script(0);
  endtask

  task automatic test_resend();
    script_q = '{OC_OK, OC_BADACK, OC_OK, OC_OK};
    run_script(0);
  endtask

  task automatic test_tx_timeout();
    script_q = '{OC_TXTO, OC_TXTO, OC_TXTO, OC_TXTO};
    run_script(0);
  endtask

  task automatic test_bat_fail();
    script_q = '{OC_BATFAIL, OC_IDBAD, OC_NOBAT, OC_OK, OC_OK, OC_OK};
    run_script(0);
  endtask

  task automatic test_no_reply();
    script_q = '{OC_OK, OC_OK, OC_NOREPLY, OC_NOREPLY, OC_NOREPLY, OC_NOREPLY};
    run_script(0);
  endtask

  // The ACK lands on the terminal-count cycle (accepted) or one cycle later (too late).
  task automatic test_timeout_boundary(input bit late);
    bit ok;
    send_count = 0;
    pulse_start();
    do_attempt(0, OC_OK, 8'hFF, ok);
    if (!ok) return;
    do_attempt(1, OC_OK, 8'hF6, ok);
    if (!ok) return;
    wait_send(ok);
    if (!ok) return;
    command_was_sent = 1'b1;
    @(negedge clk);
    command_was_sent = 1'b0;
    repeat (T25 - 1) @(negedge clk);
    @(negedge clk);
    if (late) @(negedge clk);
    received_data    = 8'hFA;
    received_data_en = 1'b1;
    @(negedge clk);
    received_data_en = 1'b0;
    received_data    = 8'h00;
    if (late) begin
      do_attempt(2, OC_OK, 8'hF4, ok);
      if (!ok) return;
    end
    wait_idle(ok);
    if (!ok) return;
    check_end(1, 0, 0, late ? 4 : 3);
  endtask

  task automatic test_reset_in_send();
    bit ok;
    pulse_start();
    wait_send(ok);
    if (!ok) return;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if ({the_command, send_command, busy, init_done, init_error, error_code} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_in_send: got cmd=%02h send=%0b busy=%0b done=%0b err=%0b code=%0d required all 0",
               the_command, send_command, busy, init_done, init_error, error_code);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (send_command !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: send=%0b busy=%0b required 0/0", send_command, busy);
    end
  endtask

  task automatic test_start_ignored();
    script_q = '{OC_OK, OC_OK, OC_OK};
    run_script(1);
  endtask

  task automatic test_random(input int n);
    bit term;
    int r;
    for (int k = 0; k < n; k++) begin
      script_q.delete();
      term = 0;
      while (!term && script_q.size() < 30) begin
        r = $urandom_range(0, 11);
        if (r <= 5) script_q.push_back(OC_OK);
        else if (r == 6) script_q.push_back(OC_TXTO);
        else if (r == 7) script_q.push_back(OC_BADACK);
        else if (r == 8) script_q.push_back(OC_NOREPLY);
        else if (r == 9) script_q.push_back(OC_BATFAIL);
        else if (r == 10) script_q.push_back(OC_IDBAD);
        else script_q.push_back(OC_TXTO);
        model_run(term);
      end
      while (!term) begin
        script_q.push_back(OC_OK);
        model_run(term);
      end
      run_script($urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    cmd_tbl[0] = 8'hFF;
    cmd_tbl[1] = 8'hF6;
    cmd_tbl[2] = 8'hF4;
    vectors     = 0;
    miscompares = 0;
    send_count  = 0;
    send_prev   = 1'b0;
    reset            = 1'b1;
    start            = 1'b0;
    received_data    = 8'h00;
    received_data_en = 1'b0;
    command_was_sent = 1'b0;
    error_communication_timed_out = 1'b0;

    test_reset();
    test_basic();
    test_resend();
    test_tx_timeout();
    test_bat_fail();
    test_no_reply();
    test_timeout_boundary(0);
    test_timeout_boundary(1);
    test_reset_in_send();
    test_start_ignored();
    test_random(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
